// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and small helpers
// reused by the receiver and the future matching transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  localparam int PAR_NONE = 32'd0;
  localparam int PAR_ODD  = 32'd1;
  localparam int PAR_EVEN = 32'd2;

  function automatic int baud_count(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // data_xor is the XOR of all payload bits; odd mode needs data^parity == 1
  function automatic logic parity_fail(input logic data_xor, input logic par_bit, input logic odd);
    return odd ? ~(data_xor ^ par_bit) : (data_xor ^ par_bit);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-period counter with strobes one clock before, at, and after the bit centre,
// plus a wrap strobe at the end of each bit period.
module uart_baud_gen #(
  parameter int CNT_MAX = 32'd10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic sample_early,
  output logic sample_mid,
  output logic sample_late,
  output logic wrap
);
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(CNT_MAX / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CNT_MAX / 2);
  localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(CNT_MAX / 2 + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: held at zero while cleared, otherwise free-running modulo CNT_MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_early = (cnt_q == CNT_EARLY);
  assign sample_mid   = (cnt_q == CNT_MID);
  assign sample_late  = (cnt_q == CNT_LATE);
  assign wrap         = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-flop synchroniser, majority-voted bit centres,
// optional parity, 1-2 stop bits and a break-safe return to idle.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 32'd50_000_000,
  parameter int UART_BPS  = 32'd9600,
  parameter int DATA_BITS = 32'd8,
  parameter int PARITY    = 32'd0,
  parameter int STOP_BITS = 32'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int BAUD_CNT_MAX = baud_count(CLK_FREQ, UART_BPS);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic PAR_IS_ODD = (PARITY == PAR_ODD);
  localparam logic PAR_USED   = (PARITY != PAR_NONE);

  uart_rx_state_t state_q, state_d;
  logic rx_s1_q, rx_s2_q, rx_s3_q;
  logic s_early_q, s_early_d, s_mid_q, s_mid_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, po_data_q, po_data_d;
  logic par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic po_flag_q, po_flag_d, parity_err_q, parity_err_d;
  logic frame_err_q, frame_err_d, busy_q, busy_d;
  logic smp_early_s, smp_mid_s, dec_s, baud_wrap_s, fall_s, bit_s;

  uart_baud_gen #(.CNT_MAX(BAUD_CNT_MAX)) u_baud (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (state_q == ST_IDLE),
    .sample_early (smp_early_s),
    .sample_mid   (smp_mid_s),
    .sample_late  (dec_s),
    .wrap         (baud_wrap_s)
  );

  assign fall_s = rx_s3_q & ~rx_s2_q;
  assign bit_s  = maj3(s_early_q, s_mid_q, rx_s2_q);

  // State register, synchroniser and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      s_early_q    <= 1'b1;
      s_mid_q      <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= {DATA_BITS{1'b0}};
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      po_data_q    <= {DATA_BITS{1'b0}};
      po_flag_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_s3_q      <= rx_s2_q;
      s_early_q    <= s_early_d;
      s_mid_q      <= s_mid_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      po_data_q    <= po_data_d;
      po_flag_q    <= po_flag_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; a low final stop bit parks in WAIT_IDLE so a break cannot retrigger
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) state_d = ST_START;
        else        state_d = ST_IDLE;
      end
      ST_START: begin
        if (dec_s) state_d = bit_s ? ST_IDLE : ST_DATA;
        else       state_d = ST_START;
      end
      ST_DATA: begin
        if (dec_s && (bit_cnt_q == DATA_LAST)) state_d = PAR_USED ? ST_PARITY : ST_STOP;
        else                                   state_d = ST_DATA;
      end
      ST_PARITY: begin
        if (dec_s) state_d = ST_STOP;
        else       state_d = ST_PARITY;
      end
      ST_STOP: begin
        if (dec_s && (bit_cnt_q == STOP_LAST)) state_d = bit_s ? ST_IDLE : ST_WAIT_IDLE;
        else                                   state_d = ST_STOP;
      end
      ST_WAIT_IDLE: begin
        if (rx_s2_q) state_d = ST_IDLE;
        else         state_d = ST_WAIT_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output logic: votes, shifting, error latching and the result strobe
  always_comb begin
    s_early_d    = s_early_q;
    s_mid_d      = s_mid_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    po_data_d    = po_data_q;
    po_flag_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = (state_d != ST_IDLE);

    // Votes from a finished bit period are discarded at the boundary
    if (smp_early_s)      s_early_d = rx_s2_q;
    else if (baud_wrap_s) s_early_d = 1'b1;
    else                  s_early_d = s_early_q;
    if (smp_mid_s)        s_mid_d = rx_s2_q;
    else if (baud_wrap_s) s_mid_d = 1'b1;
    else                  s_mid_d = s_mid_q;

    if (state_d != state_q) bit_cnt_d = 4'd0;
    else if (dec_s)         bit_cnt_d = bit_cnt_q + 4'd1;
    else                    bit_cnt_d = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
      end
      ST_DATA: begin
        if (dec_s) shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
        else       shift_d = shift_q;
      end
      ST_PARITY: begin
        if (dec_s) par_err_d = parity_fail(^shift_q, bit_s, PAR_IS_ODD);
        else       par_err_d = par_err_q;
      end
      ST_STOP: begin
        if (dec_s) begin
          frm_err_d = frm_err_q | ~bit_s;
          if (bit_cnt_q == STOP_LAST) begin
            po_flag_d    = 1'b1;
            po_data_d    = shift_q;
            parity_err_d = par_err_q;
            frame_err_d  = frm_err_q | ~bit_s;
          end else begin
            po_flag_d = 1'b0;
          end
        end else begin
          frm_err_d = frm_err_q;
        end
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
  end

  assign po_data    = po_data_q;
  assign po_flag    = po_flag_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance at 10 clocks per bit, directed
// vectors and corner sequences plus randomized frames checked by a scoreboard.
module tb_uart_rx_cfg;
  localparam int BIT_CLK = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, rx_a, rx_b;
  logic [7:0] po_data_a;
  logic [6:0] po_data_b;
  logic po_flag_a, parity_err_a, frame_err_a, busy_a;
  logic po_flag_b, parity_err_b, frame_err_b, busy_b;

  uart_rx_cfg #(.CLK_FREQ(1_000_000), .UART_BPS(100_000)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .rx(rx_a), .po_data(po_data_a), .po_flag(po_flag_a),
    .parity_err(parity_err_a), .frame_err(frame_err_a), .busy(busy_a));

  uart_rx_cfg #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .rx(rx_b), .po_data(po_data_b), .po_flag(po_flag_b),
    .parity_err(parity_err_b), .frame_err(frame_err_b), .busy(busy_b));

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } rec_t;

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       par;
    logic       s0;
    logic       s1;
    int         gl;
    logic [8:0] x_data;
    logic       x_perr;
    logic       x_ferr;
    logic       x_busy;
  } vec_t;

  rec_t exp_a[$];
  rec_t exp_b[$];
  rec_t ea, eb;
  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Scoreboard for the 8N1 instance: each pulse must match the oldest expected word
  always @(negedge clk) begin
    if (po_flag_a) begin
      check("a_pulse_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        ea = exp_a.pop_front();
        check("a_data", 32'(po_data_a), 32'(ea.data));
        check("a_parity_err", 32'(parity_err_a), 32'(ea.perr));
        check("a_frame_err", 32'(frame_err_a), 32'(ea.ferr));
        check("a_busy_at_flag", 32'(busy_a), 32'(ea.busy));
      end
    end
  end

  // Scoreboard for the 7E2 instance
  always @(negedge clk) begin
    if (po_flag_b) begin
      check("b_pulse_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        eb = exp_b.pop_front();
        check("b_data", 32'(po_data_b), 32'(eb.data));
        check("b_parity_err", 32'(parity_err_b), 32'(eb.perr));
        check("b_frame_err", 32'(frame_err_b), 32'(eb.ferr));
        check("b_busy_at_flag", 32'(busy_b), 32'(eb.busy));
      end
    end
  end

  // Drive n line bits (bit 0 first), each BIT_CLK clocks; bit gl gets a 1-clock flip at its centre
  task automatic drive_bits(input int which, input logic [15:0] bits, input int n, input int gl);
    logic v;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        @(negedge clk);
        v = bits[i];
        if (i == gl && c == 6) v = ~v;
        if (which == 0) rx_a = v;
        else            rx_b = v;
      end
    end
  endtask

  task automatic idle_one(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 0) rx_a = 1'b1;
      else            rx_b = 1'b1;
    end
  endtask

  // Reference model: expectations follow from the word and the line bits actually sent
  task automatic send_a(input logic [7:0] d, input logic stop, input int gl);
    rec_t r;
    r = '{data: {1'b0, d}, perr: 1'b0, ferr: ~stop, busy: ~stop};
    exp_a.push_back(r);
    drive_bits(0, {6'd0, stop, d, 1'b0}, 10, gl);
  endtask

  task automatic send_b(input logic [6:0] d, input logic p, input logic s0, input logic s1);
    rec_t r;
    r = '{data: {2'b00, d}, perr: ((^d) ^ p), ferr: ~(s0 & s1), busy: ~s1};
    exp_b.push_back(r);
    drive_bits(1, {5'd0, s1, s0, p, d, 1'b0}, 11, -1);
  endtask

  vec_t vt[6];
  rec_t r;
  logic saw;

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    vt[0] = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{0, 9'h00F, 1'b0, 1'b1, 1'b1,  3, 9'h00F, 1'b0, 1'b0, 1'b0};
    vt[2] = '{0, 9'h055, 1'b0, 1'b0, 1'b1, -1, 9'h055, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1, 9'h035, 1'b0, 1'b1, 1'b1, -1, 9'h035, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1, 9'h035, 1'b1, 1'b1, 1'b1, -1, 9'h035, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1, 9'h02A, 1'b1, 1'b0, 1'b1, -1, 9'h02A, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_a_po_data", 32'(po_data_a), 32'd0);
    check("rst_a_flag_err", 32'({po_flag_a, parity_err_a, frame_err_a}), 32'd0);
    check("rst_a_busy", 32'(busy_a), 32'd0);
    check("rst_b_po_data", 32'(po_data_b), 32'd0);
    check("rst_b_flag_err_busy", 32'({po_flag_b, parity_err_b, frame_err_b, busy_b}), 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    idle_one(0, 10);

    // Directed table: 8N1 nominal, centre glitch, bad stop; 7E2 good/bad parity, bad first stop
    for (int i = 0; i < 6; i++) begin
      r = '{data: vt[i].x_data, perr: vt[i].x_perr, ferr: vt[i].x_ferr, busy: vt[i].x_busy};
      if (vt[i].dut == 0) begin
        exp_a.push_back(r);
        drive_bits(0, {6'd0, vt[i].s0, vt[i].data[7:0], 1'b0}, 10, vt[i].gl);
        idle_one(0, 20);
        check($sformatf("vec%0d_a_pulse_seen", i), exp_a.size(), 32'd0);
        check($sformatf("vec%0d_a_busy_idle", i), 32'(busy_a), 32'd0);
      end else begin
        exp_b.push_back(r);
        drive_bits(1, {5'd0, vt[i].s1, vt[i].s0, vt[i].par, vt[i].data[6:0], 1'b0}, 11, -1);
        idle_one(1, 20);
        check($sformatf("vec%0d_b_pulse_seen", i), exp_b.size(), 32'd0);
        check($sformatf("vec%0d_b_busy_idle", i), 32'(busy_b), 32'd0);
      end
    end

    // False start: 3 clocks low must be rejected
    saw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rx_a = 1'b0;
      saw = saw | busy_a;
    end
    @(negedge clk);
    rx_a = 1'b1;
    saw = saw | busy_a;
    for (int k = 0; k < 10 && busy_a; k++) begin
      @(negedge clk);
      saw = saw | busy_a;
    end
    check("glitch_busy_seen", 32'(saw), 32'd1);
    check("glitch_busy_clear", 32'(busy_a), 32'd0);
    idle_one(0, 20);

    // Break: one all-zero frame with frame error, then silence until the line recovers
    r = '{data: 9'h000, perr: 1'b0, ferr: 1'b1, busy: 1'b1};
    exp_a.push_back(r);
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      rx_a = 1'b0;
    end
    check("break_pulse_seen", exp_a.size(), 32'd0);
    check("break_busy_held", 32'(busy_a), 32'd1);
    idle_one(0, 25);
    check("break_busy_clear", 32'(busy_a), 32'd0);

    // Back-to-back frames with no idle gap
    send_a(8'h12, 1'b1, -1);
    send_a(8'h34, 1'b1, -1);
    send_a(8'h56, 1'b1, -1);
    idle_one(0, 20);
    check("b2b_pulses_seen", exp_a.size(), 32'd0);

    // Reset in the middle of a frame, then a clean frame
    drive_bits(0, {6'd0, 1'b1, 8'h9A, 1'b0}, 4, -1);
    check("midframe_busy", 32'(busy_a), 32'd1);
    rst_a_n = 1'b0;
    rx_a = 1'b1;
    #1;
    check("midreset_po_data", 32'(po_data_a), 32'd0);
    check("midreset_flags", 32'({po_flag_a, parity_err_a, frame_err_a, busy_a}), 32'd0);
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    idle_one(0, 20);
    send_a(8'h78, 1'b1, -1);
    idle_one(0, 20);
    check("post_reset_pulse_seen", exp_a.size(), 32'd0);

    // Randomized frames on both instances concurrently
    fork
      begin
        logic [7:0] d;
        logic st;
        int gl;
        for (int i = 0; i < 30; i++) begin
          d = 8'($urandom);
          st = ($urandom_range(0, 7) != 0);
          if ($urandom_range(0, 3) == 0) gl = int'($urandom_range(1, 8));
          else                           gl = -1;
          send_a(d, st, gl);
          if (st) idle_one(0, int'($urandom_range(0, 12)));
          else    idle_one(0, int'($urandom_range(3, 12)));
        end
      end
      begin
        logic [6:0] d;
        logic p, s0, s1;
        for (int i = 0; i < 30; i++) begin
          d = 7'($urandom);
          p = 1'($urandom);
          s0 = ($urandom_range(0, 7) != 0);
          s1 = ($urandom_range(0, 7) != 0);
          send_b(d, p, s0, s1);
          if (s1) idle_one(1, int'($urandom_range(0, 12)));
          else    idle_one(1, int'($urandom_range(3, 12)));
        end
      end
    join
    repeat (30) @(negedge clk);
    check("rand_a_all_seen", exp_a.size(), 32'd0);
    check("rand_b_all_seen", exp_b.size(), 32'd0);
    check("rand_idle_busy", 32'({busy_a, busy_b}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
